// File: rtl/iic_arb2.sv
// Two-client I2C command arbiter: latches RX/TX sequencer requests, grants one
// iic_dri instance round-robin, routes byte completions back and aborts stalled transfers.
module iic_arb2 #(
  parameter int              TO_W    = 24,
  parameter logic [TO_W-1:0] TIMEOUT = 24'd1_000_000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  c0_device_id,
  input  logic        c0_iic_trig,
  input  logic        c0_w_r,
  input  logic [15:0] c0_addr,
  input  logic [7:0]  c0_data_in,
  output logic        c0_busy,
  output logic        c0_byte_over,
  output logic [7:0]  c0_data_out,
  input  logic [7:0]  c1_device_id,
  input  logic        c1_iic_trig,
  input  logic        c1_w_r,
  input  logic [15:0] c1_addr,
  input  logic [7:0]  c1_data_in,
  output logic        c1_busy,
  output logic        c1_byte_over,
  output logic [7:0]  c1_data_out,
  output logic [7:0]  m_device_id,
  output logic        m_w_r,
  output logic [15:0] m_addr,
  output logic [7:0]  m_data_in,
  output logic        m_pluse,
  input  logic        m_busy,
  input  logic        m_byte_over,
  input  logic [7:0]  m_data_out,
  output logic        grant,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_XFER,
    S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic            grant_nxt;
  logic            abort;
  logic            last_grant;
  logic            pend0, pend1;
  logic [7:0]      h0_id, h1_id;
  logic            h0_wr, h1_wr;
  logic [15:0]     h0_addr, h1_addr;
  logic [7:0]      h0_data, h1_data;
  logic [TO_W-1:0] wd, wd_inc;
  logic            wd_hit;
  logic            in_flight;

  assign c0_busy   = pend0;
  assign c1_busy   = pend1;
  assign in_flight = (state == S_WAIT_BUSY) || (state == S_XFER);

  // The hit compares the count including the current cycle, so TIMEOUT cycles are allowed.
  assign wd_inc = (wd == '1) ? wd : wd + 1'b1;
  assign wd_hit = (wd_inc == TIMEOUT);

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    abort     = 1'b0;
    case (state)
      S_IDLE: begin
        if (pend0 && pend1) begin
          grant_nxt = ~last_grant;
          state_nxt = S_ISSUE;
        end else if (pend0) begin
          grant_nxt = 1'b0;
          state_nxt = S_ISSUE;
        end else if (pend1) begin
          grant_nxt = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: state_nxt = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (m_busy) begin
          state_nxt = S_XFER;
        end else if (wd_hit) begin
          state_nxt = S_DONE;
          abort     = 1'b1;
        end
      end
      S_XFER: begin
        if (!m_busy) begin
          state_nxt = S_DONE;
        end else if (wd_hit) begin
          state_nxt = S_DONE;
          abort     = 1'b1;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= S_IDLE;
      grant       <= 1'b0;
      last_grant  <= 1'b1;
      m_pluse     <= 1'b0;
      timeout_err <= 1'b0;
      wd          <= '0;
    end else begin
      state       <= state_nxt;
      grant       <= grant_nxt;
      m_pluse     <= (state_nxt == S_ISSUE);
      timeout_err <= abort;
      if (state == S_DONE) last_grant <= grant;
      if (state == S_ISSUE || (state == S_WAIT_BUSY && m_busy)) begin
        wd <= '0;
      end else if (in_flight) begin
        wd <= wd_inc;
      end
    end
  end

  // A granted client's pend drops in DONE, and a trigger on that same edge is dropped too.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pend0 <= 1'b0;
      pend1 <= 1'b0;
    end else begin
      if (state == S_DONE && !grant)   pend0 <= 1'b0;
      else if (c0_iic_trig && !pend0)  pend0 <= 1'b1;
      if (state == S_DONE && grant)    pend1 <= 1'b0;
      else if (c1_iic_trig && !pend1)  pend1 <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (c0_iic_trig && !pend0) begin
      h0_id   <= c0_device_id;
      h0_wr   <= c0_w_r;
      h0_addr <= c0_addr;
      h0_data <= c0_data_in;
    end
    if (c1_iic_trig && !pend1) begin
      h1_id   <= c1_device_id;
      h1_wr   <= c1_w_r;
      h1_addr <= c1_addr;
      h1_data <= c1_data_in;
    end
  end

  // Command fields load as ISSUE is entered and hold until the next ISSUE.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      m_device_id <= '0;
      m_w_r       <= 1'b0;
      m_addr      <= '0;
      m_data_in   <= '0;
    end else if (state == S_IDLE && state_nxt == S_ISSUE) begin
      m_device_id <= grant_nxt ? h1_id   : h0_id;
      m_w_r       <= grant_nxt ? h1_wr   : h0_wr;
      m_addr      <= grant_nxt ? h1_addr : h0_addr;
      m_data_in   <= grant_nxt ? h1_data : h0_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      c0_byte_over <= 1'b0;
      c1_byte_over <= 1'b0;
      c0_data_out  <= '0;
      c1_data_out  <= '0;
    end else begin
      c0_byte_over <= in_flight && m_byte_over && !grant;
      c1_byte_over <= in_flight && m_byte_over && grant;
      if (in_flight && m_byte_over && !grant) c0_data_out <= m_data_out;
      if (in_flight && m_byte_over && grant)  c1_data_out <= m_data_out;
    end
  end

endmodule
